// File: rtl/legup_mutex_pkg.sv
// Shared definitions for the LegUp hardware mutex requester and mutex slave.
package legup_mutex_pkg;

    localparam int   OWNER_W      = 32;
    localparam int   ATTEMPT_W    = 16;
    localparam int   BACKOFF_W    = 8;
    localparam logic ADDR_ACQUIRE = 1'b0;
    localparam logic ADDR_RELEASE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ACQ_WR   = 3'd1,
        ST_ACQ_RD   = 3'd2,
        ST_ACQ_WAIT = 3'd3,
        ST_BACKOFF  = 3'd4,
        ST_LOCKED   = 3'd5,
        ST_REL_WR   = 3'd6
    } mutex_state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [ATTEMPT_W-1:0] sat_inc(input logic [ATTEMPT_W-1:0] v);
        return (v == '1) ? v : v + ATTEMPT_W'(1);
    endfunction

endpackage

// File: rtl/legup_mutex_requester.sv
// Avalon-MM master that acquires and releases a shared hardware mutex on
// behalf of one accelerator: write own ID, read back owner, retry after a
// fixed backoff until the read-back matches, then hold until released.
module legup_mutex_requester
    import legup_mutex_pkg::*;
#(
    parameter logic [OWNER_W-1:0] ACCEL_ID       = 32'd1,
    parameter int                 BACKOFF_CYCLES = 4
) (
    input  logic                 csi_clockreset_clk,
    input  logic                 csi_clockreset_reset,
    input  logic                 lock_req,
    input  logic                 unlock_req,
    output logic                 lock_granted,
    output logic                 unlock_done,
    output logic                 busy,
    output logic [ATTEMPT_W-1:0] attempt_count,
    output logic                 avm_m0_address,
    output logic                 avm_m0_write,
    output logic                 avm_m0_read,
    output logic [OWNER_W-1:0]   avm_m0_writedata,
    input  logic [OWNER_W-1:0]   avm_m0_readdata,
    input  logic                 avm_m0_readdatavalid,
    input  logic                 avm_m0_waitrequest
);

    // An ID of zero would be indistinguishable from a free mutex.
    generate
        if (ACCEL_ID == '0) begin : g_bad_accel_id
            $error("legup_mutex_requester: ACCEL_ID must be non-zero");
        end
        if ((BACKOFF_CYCLES < 1) || (BACKOFF_CYCLES > 255)) begin : g_bad_backoff
            $error("legup_mutex_requester: BACKOFF_CYCLES must be in 1..255");
        end
    endgenerate

    mutex_state_t         r_state;
    mutex_state_t         w_next_state;
    logic [BACKOFF_W-1:0] r_backoff;
    logic [ATTEMPT_W-1:0] r_attempts;
    logic                 r_lock_granted;
    logic                 r_unlock_done;
    logic                 r_write;
    logic                 r_read;
    logic                 r_address;
    logic [OWNER_W-1:0]   r_writedata;

    logic                 w_write;
    logic                 w_read;
    logic                 w_address;
    logic [OWNER_W-1:0]   w_writedata;
    logic                 w_acq_accept;
    logic                 w_rel_accept;
    logic                 w_rsp_valid;
    logic                 w_owner_match;

    assign w_acq_accept  = (r_state == ST_ACQ_WR) && !avm_m0_waitrequest;
    assign w_rel_accept  = (r_state == ST_REL_WR) && !avm_m0_waitrequest;
    // Read responses only mean something while we are waiting for one.
    assign w_rsp_valid   = (r_state == ST_ACQ_WAIT) && avm_m0_readdatavalid;
    assign w_owner_match = (avm_m0_readdata == ACCEL_ID);

    // State register.
    always_ff @(posedge csi_clockreset_clk) begin
        if (csi_clockreset_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; a started acquisition runs until it is granted.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (lock_req) w_next_state = ST_ACQ_WR;
            end
            ST_ACQ_WR: begin
                if (!avm_m0_waitrequest) w_next_state = ST_ACQ_RD;
            end
            ST_ACQ_RD: begin
                if (!avm_m0_waitrequest) w_next_state = ST_ACQ_WAIT;
            end
            ST_ACQ_WAIT: begin
                if (w_rsp_valid) w_next_state = w_owner_match ? ST_LOCKED : ST_BACKOFF;
            end
            ST_BACKOFF: begin
                if (r_backoff <= BACKOFF_W'(1)) w_next_state = ST_ACQ_WR;
            end
            ST_LOCKED: begin
                if (unlock_req) w_next_state = ST_REL_WR;
            end
            ST_REL_WR: begin
                if (!avm_m0_waitrequest) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Bus drive for the upcoming state, so the strobes leave a register.
    always_comb begin
        w_write     = 1'b0;
        w_read      = 1'b0;
        w_address   = ADDR_ACQUIRE;
        w_writedata = '0;
        case (w_next_state)
            ST_ACQ_WR: begin
                w_write     = 1'b1;
                w_writedata = ACCEL_ID;
            end
            ST_ACQ_RD: begin
                w_read = 1'b1;
            end
            ST_REL_WR: begin
                w_write     = 1'b1;
                w_address   = ADDR_RELEASE;
                w_writedata = ACCEL_ID;
            end
            default: ;
        endcase
    end

    // Registered Avalon outputs and status flags; state holds under waitrequest.
    always_ff @(posedge csi_clockreset_clk) begin
        if (csi_clockreset_reset) begin
            r_write        <= 1'b0;
            r_read         <= 1'b0;
            r_address      <= ADDR_ACQUIRE;
            r_writedata    <= '0;
            r_lock_granted <= 1'b0;
            r_unlock_done  <= 1'b0;
        end else begin
            r_write        <= w_write;
            r_read         <= w_read;
            r_address      <= w_address;
            r_writedata    <= w_writedata;
            r_lock_granted <= (w_next_state == ST_LOCKED);
            r_unlock_done  <= w_rel_accept;
        end
    end

    // Attempt counter and backoff down-counter.
    always_ff @(posedge csi_clockreset_clk) begin
        if (csi_clockreset_reset) begin
            r_attempts <= '0;
            r_backoff  <= '0;
        end else begin
            if ((r_state == ST_IDLE) && lock_req) begin
                r_attempts <= '0;
            end else if (w_acq_accept) begin
                r_attempts <= sat_inc(r_attempts);
            end

            if (w_rsp_valid && !w_owner_match) begin
                r_backoff <= BACKOFF_W'(BACKOFF_CYCLES);
            end else if ((r_state == ST_BACKOFF) && (r_backoff != '0)) begin
                r_backoff <= r_backoff - BACKOFF_W'(1);
            end
        end
    end

    assign busy             = (r_state != ST_IDLE) && (r_state != ST_LOCKED);
    assign lock_granted     = r_lock_granted;
    assign unlock_done      = r_unlock_done;
    assign attempt_count    = r_attempts;
    assign avm_m0_write     = r_write;
    assign avm_m0_read      = r_read;
    assign avm_m0_address   = r_address;
    assign avm_m0_writedata = r_writedata;

endmodule

// File: tb/tb_legup_mutex_requester.sv
// Bench for legup_mutex_requester: a mutex slave model with programmable
// stalls, read latency and a foreign owner, a transaction-level model of
// what the requester must report, and directed scenarios.
`timescale 1ns/1ps
module tb_legup_mutex_requester;
    import legup_mutex_pkg::*;

    localparam logic [31:0] ID      = 32'd5;
    localparam int          BO      = 4;
    localparam logic [31:0] FOREIGN = 32'd7;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lock_req = 1'b0;
    logic        unlock_req = 1'b0;
    logic        lock_granted, unlock_done, busy;
    logic [15:0] attempt_count;
    logic        address, write, read;
    logic [31:0] wdata;
    logic [31:0] rdata = 32'd0;
    logic        rdv = 1'b0;
    logic        wr = 1'b0;

    always #5 clk = ~clk;

    legup_mutex_requester #(.ACCEL_ID(ID), .BACKOFF_CYCLES(BO)) dut (
        .csi_clockreset_clk   (clk),
        .csi_clockreset_reset (rst),
        .lock_req             (lock_req),
        .unlock_req           (unlock_req),
        .lock_granted         (lock_granted),
        .unlock_done          (unlock_done),
        .busy                 (busy),
        .attempt_count        (attempt_count),
        .avm_m0_address       (address),
        .avm_m0_write         (write),
        .avm_m0_read          (read),
        .avm_m0_writedata     (wdata),
        .avm_m0_readdata      (rdata),
        .avm_m0_readdatavalid (rdv),
        .avm_m0_waitrequest   (wr)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Requester model: acquiring / owning / releasing, attempts, done pulse.
    bit m_acq, m_owned, m_rel, m_udone, m_rd_pending;
    int m_att;
    bit was_idle, was_locked;

    // Mutex slave model.
    logic [31:0] owner = 32'd0;
    int  acq_stall = 0, rel_stall = 0, stall_left = 0, rd_lat = 1;
    bit  in_txn, zero_next_rd;
    int  release_after = 0, foreign_fails = 0, fail_total = 0;
    int  fail_cyc = 0;
    bit  fail_pending;
    int  acq_acc = 0, rel_acc = 0, stall_cnt = 0;
    typedef struct packed { int due; logic [31:0] data; } rsp_t;
    rsp_t rsp_q[$];
    rsp_t rsp;

    bit          chk_en, p_stall;
    logic        p_write, p_read, p_addr;
    logic [31:0] p_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    // Slave, model and per-cycle compare: check and drive at negedge, observe at posedge.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("lock_granted", 32'(lock_granted), 32'(m_owned && !m_rel));
                chk("unlock_done", 32'(unlock_done), 32'(m_udone));
                chk("busy", 32'(busy), 32'(m_acq || m_rel));
                chk("attempt_count", 32'(attempt_count), 32'(m_att));
                chk("wr_and_rd", 32'(write && read), 32'd0);
                chk("writedata", wdata, write ? ID : 32'd0);
                if (write) chk("wr_addr", 32'(address), 32'(m_rel));
                if (read)  chk("rd_addr", 32'(address), 32'd0);
                chk("strobe_ctx", 32'((write || read) && !m_acq && !m_rel), 32'd0);
                if (p_stall) begin
                    chk("stall_hold_ctl", 32'({write, read, address}), 32'({p_write, p_read, p_addr}));
                    chk("stall_hold_data", wdata, p_wdata);
                end
            end
            if (write || read) begin
                if (!in_txn) begin
                    in_txn = 1'b1;
                    stall_left = 0;
                    if (write && !address) begin
                        stall_left = acq_stall;
                        acq_stall = 0;
                        if (fail_pending) begin
                            chk("backoff_gap", 32'(cyc - fail_cyc), 32'(BO + 1));
                            fail_pending = 1'b0;
                        end
                    end else if (write) begin
                        stall_left = rel_stall;
                        rel_stall = 0;
                    end
                end
                wr = (stall_left > 0);
                if (stall_left > 0) stall_left--;
            end else begin
                wr = 1'b0;
            end
            if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
                rdv = 1'b1;
                rdata = rsp_q[0].data;
                void'(rsp_q.pop_front());
                if (m_rd_pending && rdata != ID) begin
                    fail_cyc = cyc;
                    fail_pending = 1'b1;
                    fail_total++;
                end
            end else begin
                rdv = 1'b0;
                rdata = 32'hDEAD_BEEF;
            end

            @(posedge clk);
            cyc++;
            p_stall = (write || read) && wr && !rst;
            p_write = write; p_read = read; p_addr = address; p_wdata = wdata;
            if (write && wr) stall_cnt++;
            if (rst) begin
                m_acq = 0; m_owned = 0; m_rel = 0; m_udone = 0; m_rd_pending = 0; m_att = 0;
                in_txn = 0; owner = 32'd0; fail_pending = 0; chk_en = 1;
            end else begin
                was_idle   = !m_acq && !m_owned && !m_rel;
                was_locked = m_owned && !m_rel;
                m_udone = 0;
                if ((write || read) && !wr) in_txn = 1'b0;
                if (write && !wr) begin
                    if (!address) begin
                        acq_acc++;
                        if (owner == 32'd0) owner = wdata;
                    end else begin
                        rel_acc++;
                        if (owner == wdata) owner = 32'd0;
                    end
                end
                if (read && !wr) begin
                    rsp.due  = cyc + rd_lat - 1;
                    rsp.data = zero_next_rd ? 32'd0 : owner;
                    zero_next_rd = 1'b0;
                    if (owner == FOREIGN) begin
                        foreign_fails++;
                        if (foreign_fails == release_after) owner = 32'd0;
                    end
                    rsp_q.push_back(rsp);
                    if (m_acq) m_rd_pending = 1'b1;
                end
                if (m_acq && write && !wr) m_att = (m_att == 65535) ? m_att : m_att + 1;
                if (m_rel && write && !wr) begin
                    m_rel = 0; m_owned = 0; m_udone = 1;
                end
                if (rdv && m_rd_pending) begin
                    m_rd_pending = 0;
                    if (rdata == ID) begin
                        m_owned = 1; m_acq = 0;
                    end
                end
                if (was_idle && lock_req) begin
                    m_acq = 1; m_att = 0;
                end else if (was_locked && unlock_req) begin
                    m_rel = 1;
                end
            end
        end
    end

    task automatic pulse_lock();
        lock_req = 1'b1;
        @(negedge clk);
        lock_req = 1'b0;
    endtask

    task automatic wait_grant(input int budget);
        int n = 0;
        while (!lock_granted && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("grant_within_budget", 32'(lock_granted), 32'd1);
    endtask

    task automatic do_release(input int budget);
        int n = 0;
        unlock_req = 1'b1;
        @(negedge clk);
        unlock_req = 1'b0;
        chk("rel_granted_low", 32'(lock_granted), 32'd0);
        chk("rel_busy", 32'(busy), 32'd1);
        while (!unlock_done && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("rel_done", 32'(unlock_done), 32'd1);
        chk("rel_owner_free", owner, 32'd0);
        chk("rel_idle", 32'(busy), 32'd0);
        @(negedge clk);
        chk("rel_done_single", 32'(unlock_done), 32'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_granted"}, 32'(lock_granted), 32'd0);
        chk({tag, "_done"}, 32'(unlock_done), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_att"}, 32'(attempt_count), 32'd0);
        chk({tag, "_write"}, 32'(write), 32'd0);
        chk({tag, "_read"}, 32'(read), 32'd0);
        chk({tag, "_addr"}, 32'(address), 32'd0);
        chk({tag, "_wdata"}, wdata, 32'd0);
    endtask

    initial begin
        int n0, a0, r0, s0, f0, n;
        #200000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int n0, a0, r0, s0, f0, n;
        // Reset state.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_reset_vals("reset");
        repeat (2) @(negedge clk);

        // Uncontended acquire: granted exactly four cycles after the request.
        a0 = acq_acc;
        n0 = cyc;
        pulse_lock();
        while (cyc < n0 + 3) @(negedge clk);
        chk("latency_n3", 32'(lock_granted), 32'd0);
        @(negedge clk);
        chk("latency_n4", 32'(lock_granted), 32'd1);
        chk("unc_attempts", 32'(attempt_count), 32'd1);
        chk("unc_owner", owner, ID);
        chk("unc_acq_writes", 32'(acq_acc - a0), 32'd1);
        do_release(20);

        // Contended: foreign owner 7 lets go after three of our reads.
        repeat (2) @(negedge clk);
        owner = FOREIGN;
        release_after = 3;
        foreign_fails = 0;
        f0 = fail_total;
        pulse_lock();
        wait_grant(300);
        chk("cont_attempts", 32'(attempt_count), 32'd4);
        chk("cont_failed_reads", 32'(fail_total - f0), 32'd3);
        chk("cont_owner", owner, ID);
        do_release(20);

        // Waitrequest stalls: 3 cycles on acquire write, 2 on release write.
        repeat (2) @(negedge clk);
        acq_stall = 3;
        rel_stall = 2;
        s0 = stall_cnt;
        a0 = acq_acc;
        pulse_lock();
        wait_grant(50);
        chk("stall_acq_writes", 32'(acq_acc - a0), 32'd1);
        chk("stall_acq_cycles", 32'(stall_cnt - s0), 32'd3);
        chk("stall_attempts", 32'(attempt_count), 32'd1);
        s0 = stall_cnt;
        r0 = rel_acc;
        do_release(20);
        chk("stall_rel_writes", 32'(rel_acc - r0), 32'd1);
        chk("stall_rel_cycles", 32'(stall_cnt - s0), 32'd2);

        // Lock and unlock together in IDLE: acquire wins, no release write.
        repeat (2) @(negedge clk);
        r0 = rel_acc;
        lock_req = 1'b1;
        unlock_req = 1'b1;
        @(negedge clk);
        lock_req = 1'b0;
        unlock_req = 1'b0;
        chk("both_busy", 32'(busy), 32'd1);
        chk("both_write", 32'(write), 32'd1);
        chk("both_addr", 32'(address), 32'd0);
        wait_grant(20);
        chk("both_no_release", 32'(rel_acc - r0), 32'd0);
        do_release(20);

        // Unlock alone in IDLE: no bus activity.
        a0 = acq_acc;
        r0 = rel_acc;
        unlock_req = 1'b1;
        @(negedge clk);
        unlock_req = 1'b0;
        repeat (4) @(negedge clk);
        chk("idle_unlock_acq", 32'(acq_acc - a0), 32'd0);
        chk("idle_unlock_rel", 32'(rel_acc - r0), 32'd0);
        chk("idle_unlock_busy", 32'(busy), 32'd0);

        // Read-back of 0 is a failed attempt.
        zero_next_rd = 1'b1;
        pulse_lock();
        wait_grant(50);
        chk("zero_attempts", 32'(attempt_count), 32'd2);
        do_release(20);

        // Reset while waiting for a slow read response.
        repeat (2) @(negedge clk);
        rd_lat = 3;
        pulse_lock();
        n = 0;
        while (!m_rd_pending && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("reached_acq_wait", 32'(m_rd_pending), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_vals("midreset");
        repeat (4) @(negedge clk);
        chk("late_rsp_delivered", 32'(rsp_q.size()), 32'd0);
        chk("late_rsp_ignored", 32'(lock_granted), 32'd0);
        chk("late_rsp_idle", 32'(busy), 32'd0);
        rd_lat = 1;
        pulse_lock();
        wait_grant(20);
        chk("post_reset_attempts", 32'(attempt_count), 32'd1);
        do_release(20);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
